// File: rtl/his_readout_pkg.sv
// Purpose : shared defaults and FSM state codes for the histogram readout block.
// Latency : n/a (constants only).
// Backpressure: n/a.
package his_readout_pkg;

    // Default bin address width and per-bin count width.
    localparam int NB_DEF    = 10;
    localparam int CNT_W_DEF = 8;

    // Readout FSM encoding, kept as plain constants for legacy tooling.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_FIN   = 2'd3;

endpackage

// File: rtl/his_readout_if.sv
// Purpose : readout beat stream (bin index, count, last flag) with valid/ready.
// Latency : n/a (wires only).
// Backpressure: transfer happens on a cycle where out_valid and out_ready are both high.
// Ports   : master drives out_valid/out_bin/out_count/out_last, slave drives out_ready.
interface his_readout_if #(
    parameter int NB    = his_readout_pkg::NB_DEF,
    parameter int CNT_W = his_readout_pkg::CNT_W_DEF
);
    logic             out_valid;
    logic             out_ready;
    logic [NB-1:0]    out_bin;
    logic [CNT_W-1:0] out_count;
    logic             out_last;

    modport master (
        output out_valid, out_bin, out_count, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_bin, out_count, out_last,
        output out_ready
    );
endinterface

// File: rtl/his_readout_fifo.sv
// Purpose : 2-entry buffer absorbing the one-cycle RAM read latency.
// Latency : 1 cycle from push to out_valid; head visible directly from storage.
// Backpressure: in_ready drops when both entries are full; head held while out_ready low.
// Ports   : clk/res, in_valid/in_ready/in_data, out_valid/out_ready/out_data, occ (0..2).
module his_readout_fifo #(
    parameter int W = 19
) (
    input  logic         clk,
    input  logic         res,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   occ
);
    logic [W-1:0] ent [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         push;
    logic         pop;

    assign in_ready  = (occ != 2'd2);
    assign out_valid = (occ != 2'd0);
    assign out_data  = ent[rd_ptr];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            ent[0] <= '0;
            ent[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                ent[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/his_readout.sv
// Purpose : sweeps a finished histogram RAM in bin order, streams (bin,count), clears each bin, tracks the peak.
// Latency : first beat 2 cycles after start; 2**NB+2 cycles per sweep at full rate; done one cycle after drain.
// Backpressure: reads throttled so buffer + in-flight reads never exceed 2; stalls never drop or reorder beats.
// Ports   : clk/res; start/busy/done; ram_rd_* read port (1-cycle latency); ram_clr_* zero-write port;
//           out (stream master); peak_bin/peak_count/peak_valid running maximum.
module his_readout
    import his_readout_pkg::*;
#(
    parameter int NB    = NB_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             res,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             ram_rd_en,
    output logic [NB-1:0]    ram_rd_addr,
    input  logic [CNT_W-1:0] ram_rd_data,
    output logic             ram_clr_en,
    output logic [NB-1:0]    ram_clr_addr,
    his_readout_if.master    out,
    output logic [NB-1:0]    peak_bin,
    output logic [CNT_W-1:0] peak_count,
    output logic             peak_valid
);
    localparam int            FW       = NB + CNT_W + 1;
    localparam logic [NB-1:0] LAST_BIN = '1;

    logic [1:0]    state;
    logic [NB-1:0] rd_addr;
    logic          rd_pend;     // read issued last cycle, data on ram_rd_data now
    logic [NB-1:0] pend_addr;   // address of that read
    logic [1:0]    occ;
    logic          fifo_in_rdy;
    logic [FW-1:0] fifo_out;
    logic          pop;
    logic [2:0]    used;
    logic [2:0]    room;

    // A beat leaving this cycle frees a slot, so count it as room; this is
    // what lets reads issue every cycle while the sink keeps up.
    assign pop  = out.out_valid && out.out_ready;
    assign used = {1'b0, occ} + {2'b0, rd_pend};
    assign room = 3'd2 + {2'b0, pop};

    assign ram_rd_en    = (state == ST_READ) && (used < room) && fifo_in_rdy;
    assign ram_rd_addr  = rd_addr;
    // The zero-write follows the read by one cycle, same address.
    assign ram_clr_en   = rd_pend;
    assign ram_clr_addr = pend_addr;

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_FIN);

    his_readout_fifo #(.W(FW)) u_fifo (
        .clk       (clk),
        .res       (res),
        .in_valid  (rd_pend),
        .in_ready  (fifo_in_rdy),
        .in_data   ({pend_addr == LAST_BIN, pend_addr, ram_rd_data}),
        .out_valid (out.out_valid),
        .out_ready (out.out_ready),
        .out_data  (fifo_out),
        .occ       (occ)
    );

    assign out.out_last  = fifo_out[FW-1];
    assign out.out_bin   = fifo_out[CNT_W +: NB];
    assign out.out_count = fifo_out[CNT_W-1:0];

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state      <= ST_IDLE;
            rd_addr    <= '0;
            rd_pend    <= 1'b0;
            pend_addr  <= '0;
            peak_bin   <= '0;
            peak_count <= '0;
            peak_valid <= 1'b0;
        end else begin
            rd_pend <= ram_rd_en;
            if (ram_rd_en) begin
                pend_addr <= rd_addr;
            end

            // Strictly greater: with ascending bins a tie keeps the lower bin.
            if (pop && (out.out_count > peak_count)) begin
                peak_bin   <= out.out_bin;
                peak_count <= out.out_count;
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_READ;
                        rd_addr    <= '0;
                        peak_bin   <= '0;
                        peak_count <= '0;
                        peak_valid <= 1'b0;
                    end
                end
                ST_READ: begin
                    if (ram_rd_en) begin
                        // Address stops at the last bin; no wrap within a sweep.
                        if (rd_addr == LAST_BIN) begin
                            state <= ST_DRAIN;
                        end else begin
                            rd_addr <= rd_addr + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Buffer empty with nothing in flight means the last beat has gone.
                    if ((occ == 2'd0) && !rd_pend) begin
                        state      <= ST_FIN;
                        peak_valid <= 1'b1;
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_his_readout.sv
// Purpose : directed checks of his_readout with NB=3 against a behavioural RAM.
// Latency : n/a.
// Backpressure: sink ready held high, randomised, or stalled on the last beat.
module tb_his_readout;
    localparam int NB    = 3;
    localparam int CW    = 8;
    localparam int NBINS = 8;

    logic          clk = 1'b0;
    logic          res;
    logic          start;
    logic          busy;
    logic          done;
    logic          ram_rd_en;
    logic [NB-1:0] ram_rd_addr;
    logic [CW-1:0] ram_rd_data;
    logic          ram_clr_en;
    logic [NB-1:0] ram_clr_addr;
    logic [NB-1:0] peak_bin;
    logic [CW-1:0] peak_count;
    logic          peak_valid;

    his_readout_if #(.NB(NB), .CNT_W(CW)) sif ();

    his_readout #(.NB(NB), .CNT_W(CW)) dut (
        .clk          (clk),
        .res          (res),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .ram_rd_en    (ram_rd_en),
        .ram_rd_addr  (ram_rd_addr),
        .ram_rd_data  (ram_rd_data),
        .ram_clr_en   (ram_clr_en),
        .ram_clr_addr (ram_clr_addr),
        .out          (sif),
        .peak_bin     (peak_bin),
        .peak_count   (peak_count),
        .peak_valid   (peak_valid)
    );

    always #5 clk = ~clk;

    logic [CW-1:0] mem     [NBINS];
    logic [CW-1:0] preload [NBINS] = '{8'd0, 8'd5, 8'd2, 8'd7, 8'd7, 8'd1, 8'd0, 8'd3};
    logic [CW-1:0] after_abort [NBINS] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd3};
    logic [CW-1:0] exp_cnt [NBINS];

    // Histogram RAM: registered read, zero-write on clear strobe.
    always @(posedge clk) begin
        if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
        if (ram_clr_en) mem[ram_clr_addr] <= '0;
    end

    int n_cmp = 0;
    int n_err = 0;
    int q_bin[$];
    int q_cnt[$];
    int q_last[$];
    int q_clr[$];
    int first_valid;
    int done_cyc;
    int done_count;
    int aborted;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ram();
        for (int i = 0; i < NBINS; i++) mem[i] = preload[i];
    endtask

    task automatic check_beats(input string tag);
        chk({tag, "_nbeats"}, 32'(q_bin.size()), NBINS);
        for (int i = 0; i < NBINS && i < q_bin.size(); i++) begin
            chk($sformatf("%s_bin%0d", tag, i), 32'(q_bin[i]), 32'(i));
            chk($sformatf("%s_cnt%0d", tag, i), 32'(q_cnt[i]), 32'(exp_cnt[i]));
            chk($sformatf("%s_last%0d", tag, i), 32'(q_last[i]), (i == NBINS - 1) ? 1 : 0);
        end
    endtask

    // mode 0: ready high; 1: random ready + stall on last; 2: re-pulse start at beat 3;
    // 3: assert reset while bin 4 is presented.
    task automatic do_sweep(input int mode);
        int nb;
        int last_stall;
        logic prev_stall;
        logic [NB-1:0] pb;
        logic [CW-1:0] pc;
        logic pl;
        q_bin.delete(); q_cnt.delete(); q_last.delete(); q_clr.delete();
        first_valid = -1; done_cyc = -1; done_count = 0; aborted = 0;
        nb = 0; last_stall = 0; prev_stall = 1'b0; pb = '0; pc = '0; pl = 1'b0;
        sif.out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", 32'(busy), 1);
        chk("start_peak_valid_clr", 32'(peak_valid), 0);
        chk("start_peak_count_clr", 32'(peak_count), 0);
        chk("start_peak_bin_clr", 32'(peak_bin), 0);
        for (int c = 0; c < 300; c++) begin
            if (prev_stall) begin
                chk("stall_valid", 32'(sif.out_valid), 1);
                chk("stall_bin", 32'(sif.out_bin), 32'(pb));
                chk("stall_cnt", 32'(sif.out_count), 32'(pc));
                chk("stall_last", 32'(sif.out_last), 32'(pl));
            end
            if (ram_clr_en) q_clr.push_back(int'(ram_clr_addr));
            if (done) begin
                done_count++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (sif.out_valid && first_valid < 0) first_valid = c;
            if (mode == 3 && sif.out_valid && sif.out_bin == 3'd4) begin
                chk("abort_beats_before", 32'(nb), 4);
                res = 1'b1;
                #1;
                chk("abort_busy", 32'(busy), 0);
                chk("abort_out_valid", 32'(sif.out_valid), 0);
                chk("abort_rd_en", 32'(ram_rd_en), 0);
                chk("abort_clr_en", 32'(ram_clr_en), 0);
                tick();
                chk("abort_peak_count", 32'(peak_count), 0);
                chk("abort_rd_addr", 32'(ram_rd_addr), 0);
                chk("abort_done", 32'(done), 0);
                res = 1'b0;
                tick();
                aborted = 1;
                return;
            end
            if (mode == 1) begin
                sif.out_ready = ($urandom_range(0, 1) == 1);
                if (sif.out_valid && sif.out_last && last_stall < 3) begin
                    sif.out_ready = 1'b0;
                    last_stall++;
                end
            end else begin
                sif.out_ready = 1'b1;
            end
            start = (mode == 2) && sif.out_valid && (nb == 3);
            if (sif.out_valid && sif.out_ready) begin
                q_bin.push_back(int'(sif.out_bin));
                q_cnt.push_back(int'(sif.out_count));
                q_last.push_back(int'(sif.out_last));
                nb++;
            end
            prev_stall = sif.out_valid && !sif.out_ready;
            pb = sif.out_bin;
            pc = sif.out_count;
            pl = sif.out_last;
            if (done_cyc >= 0 && c >= done_cyc + 6) break;
            tick();
        end
        start = 1'b0;
        sif.out_ready = 1'b1;
        if (done_cyc < 0) chk("sweep_timeout", 0, 1);
    endtask

    initial begin
        res = 1'b1;
        start = 1'b0;
        sif.out_ready = 1'b0;
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_rd_en", 32'(ram_rd_en), 0);
        chk("rst_clr_en", 32'(ram_clr_en), 0);
        chk("rst_out_valid", 32'(sif.out_valid), 0);
        chk("rst_out_last", 32'(sif.out_last), 0);
        chk("rst_peak_valid", 32'(peak_valid), 0);
        chk("rst_peak_bin", 32'(peak_bin), 0);
        chk("rst_peak_count", 32'(peak_count), 0);
        chk("rst_rd_addr", 32'(ram_rd_addr), 0);
        res = 1'b0;
        tick();

        // Full-rate sweep of the reference histogram.
        load_ram();
        exp_cnt = preload;
        do_sweep(0);
        check_beats("a");
        chk("a_first_valid_cyc", 32'(first_valid), 2);
        chk("a_done_cyc", 32'(done_cyc), 11);
        chk("a_done_count", 32'(done_count), 1);
        chk("a_peak_bin", 32'(peak_bin), 3);
        chk("a_peak_count", 32'(peak_count), 7);
        chk("a_peak_valid", 32'(peak_valid), 1);
        chk("a_busy_after", 32'(busy), 0);
        chk("a_nclr", 32'(q_clr.size()), NBINS);
        for (int i = 0; i < NBINS && i < q_clr.size(); i++)
            chk($sformatf("a_clr_addr%0d", i), 32'(q_clr[i]), 32'(i));
        for (int i = 0; i < NBINS; i++)
            chk($sformatf("a_ram_zero%0d", i), 32'(mem[i]), 0);

        // Second sweep over the cleared RAM.
        for (int i = 0; i < NBINS; i++) exp_cnt[i] = '0;
        do_sweep(0);
        check_beats("b");
        chk("b_peak_bin", 32'(peak_bin), 0);
        chk("b_peak_count", 32'(peak_count), 0);
        chk("b_peak_valid", 32'(peak_valid), 1);

        // Random backpressure, including stalls on the last beat.
        load_ram();
        exp_cnt = preload;
        do_sweep(1);
        check_beats("c");
        chk("c_done_count", 32'(done_count), 1);
        chk("c_peak_bin", 32'(peak_bin), 3);
        chk("c_peak_count", 32'(peak_count), 7);

        // Start re-pulsed mid-sweep.
        load_ram();
        exp_cnt = preload;
        do_sweep(2);
        check_beats("d");
        chk("d_done_count", 32'(done_count), 1);
        chk("d_done_cyc", 32'(done_cyc), 11);
        chk("d_nclr", 32'(q_clr.size()), NBINS);

        // Reset while bin 4 is on the output.
        load_ram();
        do_sweep(3);
        chk("e_aborted", 32'(aborted), 1);
        for (int i = 0; i < NBINS; i++)
            chk($sformatf("e_ram%0d", i), 32'(mem[i]), 32'(after_abort[i]));

        // Fresh start after the abort sweeps from bin 0 over what survived.
        exp_cnt = after_abort;
        do_sweep(0);
        check_beats("f");
        chk("f_first_valid_cyc", 32'(first_valid), 2);
        chk("f_done_cyc", 32'(done_cyc), 11);
        chk("f_peak_bin", 32'(peak_bin), 7);
        chk("f_peak_count", 32'(peak_count), 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/his_readout.md
HIS_READOUT -- requirements
Module: his_readout

Interface
REQ-001 Parameter NB, default 10, bin address width; histogram holds 2**NB bins, addresses 0..2**NB-1.
REQ-002 Parameter CNT_W, default 8, per-bin count width (peakMax).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 res  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  one-cycle pulse from histogram builder (acq_count_finish); requests readout of the completed histogram.
REQ-006 busy  out  1  high from accepted start until done.
REQ-007 done  out  1  one-cycle pulse after last bin is accepted downstream.
REQ-008 ram_rd_en  out  1  histogram RAM read strobe.
REQ-009 ram_rd_addr  out  NB  read address.
REQ-010 ram_rd_data  in  CNT_W  read data, valid exactly one cycle after ram_rd_en.
REQ-011 ram_clr_en  out  1  write-zero strobe (read-clear of consumed bin).
REQ-012 ram_clr_addr  out  NB  address being cleared.
REQ-013 out_valid / out_ready  out / in  1 / 1  stream handshake; transfer when both high.
REQ-014 out_bin  out  NB  bin index of current beat.
REQ-015 out_count  out  CNT_W  count of current beat.
REQ-016 out_last  out  1  high on beat for bin 2**NB-1.
REQ-017 peak_bin / peak_count  out  NB / CNT_W  running maximum of streamed histogram.
REQ-018 peak_valid  out  1  high from done until next accepted start.

Function
REQ-019 States: IDLE, READ, DRAIN, FIN; IDLE->READ on start; READ->DRAIN after read of bin 2**NB-1 issued; DRAIN->FIN when buffer empty and last beat accepted; FIN->IDLE next cycle with done=1 in FIN.
REQ-020 start while busy is ignored; start in IDLE clears peak_valid, peak_bin, peak_count and read address to 0.
REQ-021 Reads issued in ascending address order, one per cycle maximum, no address skipped or repeated.
REQ-022 Read issued only when (buffer occupancy + reads in flight) < 2; 2-entry FIFO absorbs read latency, so out_ready low never loses data.
REQ-023 With out_ready held high, one beat per cycle; first out_valid 2 cycles after start, full sweep completes in 2**NB+2 cycles, done at cycle 2**NB+3.
REQ-024 out_bin/out_count/out_last stable while out_valid high and out_ready low.
REQ-025 ram_clr_en pulses one cycle after each read, ram_clr_addr equal to that read address; every bin cleared exactly once per sweep.
REQ-026 Peak update on each accepted beat: replace only if out_count strictly greater than peak_count; ties keep lower bin; all-zero histogram yields peak_bin=0, peak_count=0.
REQ-027 Address counter does not wrap: no read after 2**NB-1 within a sweep.
REQ-028 out_ready may toggle arbitrarily, including low on last beat; done waits for last transfer.

Reset
REQ-029 On res high: state IDLE; busy, done, ram_rd_en, ram_clr_en, out_valid, out_last, peak_valid = 0; all addresses, counts, peak registers, FIFO pointers = 0.
REQ-030 Reset mid-sweep aborts immediately; in-flight read data discarded; remaining bins not cleared.

Structure
REQ-031 NB/CNT_W defaults and state encoding in shared parametersSiFH.vh (reuse Nb, peakMax).
REQ-032 One sub-module: his_readout_fifo (2-entry, NB+CNT_W+1 wide, valid/ready both sides).

Verification
REQ-033 NB=3, RAM preloaded {0,5,2,7,7,1,0,3}, out_ready=1, start -> 8 beats bins 0..7 in order, out_last on bin 7, peak_bin=3, peak_count=7, done at cycle 11.
REQ-034 Same data, out_ready random 50% -> identical beat sequence, no drop/duplicate, output stable while stalled.
REQ-035 After sweep -> RAM all zero, 8 ram_clr_en pulses addresses 0..7; second sweep gives peak_count=0, peak_bin=0.
REQ-036 start pulsed again at beat 3 -> ignored, single sweep, single done.
REQ-037 res asserted at beat 4 -> all outputs 0 next edge, bins 5..7 retain contents, new start restarts from bin 0.
